// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with seed load, zero-seed protection and an optional
// period monitor, built only when LFSR_PERIOD_MON_EN is defined.
module lfsr_gen #(
  parameter int unsigned WIDTH    = 16,
  parameter logic [31:0] TAP_MASK = 32'h0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] state,
  output logic             zero_fixed,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             maximal,
  output logic             timeout
);

  // Maximal-length taps, bit i = state bit i
  function automatic logic [31:0] max_taps(input int unsigned w);
    logic [31:0] m;
    case (w)
      4:       m = 32'h0000_000C;
      5:       m = 32'h0000_0014;
      6:       m = 32'h0000_0030;
      7:       m = 32'h0000_0060;
      8:       m = 32'h0000_00B8;
      9:       m = 32'h0000_0110;
      10:      m = 32'h0000_0240;
      11:      m = 32'h0000_0500;
      12:      m = 32'h0000_0829;
      13:      m = 32'h0000_100D;
      14:      m = 32'h0000_2015;
      15:      m = 32'h0000_6000;
      16:      m = 32'h0000_D008;
      17:      m = 32'h0001_2000;
      18:      m = 32'h0002_0400;
      19:      m = 32'h0004_0023;
      20:      m = 32'h0009_0000;
      21:      m = 32'h0014_0000;
      22:      m = 32'h0030_0000;
      23:      m = 32'h0042_0000;
      24:      m = 32'h00E1_0000;
      25:      m = 32'h0120_0000;
      26:      m = 32'h0200_0023;
      27:      m = 32'h0400_0013;
      28:      m = 32'h0900_0000;
      29:      m = 32'h1400_0000;
      30:      m = 32'h2000_0029;
      31:      m = 32'h4800_0000;
      32:      m = 32'h8020_0003;
      default: m = 32'h0;
    endcase
    return m;
  endfunction

  localparam logic [31:0]      MaskFull = (TAP_MASK != 32'h0) ? TAP_MASK : max_taps(WIDTH);
  localparam logic [WIDTH-1:0] Mask     = MaskFull[WIDTH-1:0];
  localparam logic [WIDTH-1:0] One      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] AllOnes  = '1;

  if (WIDTH < 4 || WIDTH > 32) begin : g_width_err
    $error("lfsr_gen: WIDTH must be within 4..32");
  end
  if ((TAP_MASK >> WIDTH) != 32'h0) begin : g_mask_err
    $error("lfsr_gen: TAP_MASK has bits set at or above WIDTH");
  end

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_val;
  logic             seed_zero;
  logic             zero_fixed_q;

  assign seed_zero = (seed == '0);
  assign load_val  = seed_zero ? One : seed;
  assign step_val  = {state_q[WIDTH-2:0], ^(state_q & Mask)};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= One;
      zero_fixed_q <= 1'b0;
    end else begin
      zero_fixed_q <= load & seed_zero;
      if (load) begin
        state_q <= load_val;
      end else if (en) begin
        state_q <= step_val;
      end
    end
  end

  assign state      = state_q;
  assign zero_fixed = zero_fixed_q;

`ifdef LFSR_PERIOD_MON_EN
  typedef enum logic [1:0] {StMeasure, StDone, StTimeout} mon_st_e;

  mon_st_e          mon_st_q;
  logic [WIDTH-1:0] start_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] period_q;
  logic [WIDTH-1:0] count_inc;
  logic             period_valid_q;
  logic             maximal_q;
  logic             timeout_q;

  assign count_inc = count_q + One;

  // Done and Timeout are sticky until the next load or reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mon_st_q       <= StMeasure;
      start_q        <= One;
      count_q        <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      maximal_q      <= 1'b0;
      timeout_q      <= 1'b0;
    end else if (load) begin
      mon_st_q       <= StMeasure;
      start_q        <= load_val;
      count_q        <= '0;
      period_valid_q <= 1'b0;
      maximal_q      <= 1'b0;
      timeout_q      <= 1'b0;
    end else if (en && mon_st_q == StMeasure) begin
      count_q <= count_inc;
      if (step_val == start_q) begin
        period_q       <= count_inc;
        period_valid_q <= 1'b1;
        maximal_q      <= (count_inc == AllOnes);
        mon_st_q       <= StDone;
      end else if (count_inc == AllOnes) begin
        timeout_q <= 1'b1;
        mon_st_q  <= StTimeout;
      end
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign maximal      = maximal_q;
  assign timeout      = timeout_q;
`else
  assign period       = '0;
  assign period_valid = 1'b0;
  assign maximal      = 1'b0;
  assign timeout      = 1'b0;
`endif

endmodule
